reg_status_table: RTL
=====================

# reg_status_table

Register-status (scoreboard) table for the out-of-order RISC-V core. It sits between the issue stage, the reorder-buffer commit port and the architectural register file. It records, per architectural register, whether an in-flight instruction will write it and which ROB tag will produce the value. It also sequences the register file's single write port from commit and clears renames on pipeline flush.

## Interface
- TAG_W, 4: ROB tag width (16-entry ROB).
- clk_in  input  1  clock, all state updates on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- flush_in  input  1  mispredict/exception flush; clears all busy bits.
- issue_valid_in  input  1  an instruction with a destination register issues this cycle.
- issue_rd_in  input  5  destination register of issuing instruction.
- issue_tag_in  input  TAG_W  ROB tag of issuing instruction.
- rs1_addr_in  input  5  source-1 lookup address.
- rs2_addr_in  input  5  source-2 lookup address.
- rs1_busy_out  output  1  source 1 is pending; take the value from ROB/CDB, not the regfile.
- rs1_tag_out  output  TAG_W  producing ROB tag for source 1 (0 when not busy).
- rs2_busy_out  output  1  as rs1_busy_out, for source 2.
- rs2_tag_out  output  TAG_W  as rs1_tag_out, for source 2.
- commit_valid_in  input  1  ROB commits an instruction writing a register.
- commit_rd_in  input  5  committed destination register.
- commit_tag_in  input  TAG_W  ROB tag of committing instruction.
- commit_data_in  input  32  committed result.
- rf_we_out  output  1  register-file write enable.
- rf_waddr_out  output  5  register-file write address.
- rf_wdata_out  output  32  register-file write data.
- busy_count_out  output  6  number of registers currently marked busy (0..31).

## Operation
- State: busy[1..31] (1 bit each) and tag[1..31] (TAG_W each). Register x0 is never busy; lookups of x0 always return busy=0, tag=0.
- Issue: when issue_valid_in=1, issue_rd_in≠0 and flush_in=0, set busy[rd]=1 and tag[rd]=issue_tag_in at the next edge. Issue with rd=0 is ignored.
- Commit: when commit_valid_in=1 and commit_rd_in≠0, drive rf_we_out=1, rf_waddr_out=commit_rd_in and rf_wdata_out=commit_data_in in the same cycle. The regfile's write-through forwarding makes the value readable that cycle. Clear busy[rd] at the next edge only if busy[rd]=1 and tag[rd]==commit_tag_in. A tag mismatch means a younger writer owns the register; the write still happens and busy is unchanged.
- Commit with rd=0: rf_we_out=0.
- Lookup (combinational): rsN_busy_out = busy[a] AND NOT (commit_valid_in AND commit_rd_in==a AND commit_tag_in==tag[a]). rsN_tag_out = tag[a] when rsN_busy_out=1, else 0.
- Lookup uses pre-issue state. An instruction whose source equals its own destination (add x1,x1,x2) sees the older producer, not itself.
- Simultaneous issue and matching commit to the same rd: issue wins; busy stays 1 and tag becomes issue_tag_in.
- Flush: at the next edge all busy bits are 0. Tags may keep stale values, but tag outputs are masked to 0 by busy. The commit write in the flush cycle still reaches the regfile. Issue in the flush cycle is dropped.
- busy_count_out is the registered popcount of busy[31:1], updated each edge from next-state.

## Timing
- Reset (rst_in=0, asynchronous): all busy=0, all tag=0, busy_count_out=0. While reset is asserted, rf_we_out=0, rf_waddr_out=0, rf_wdata_out=0, all rs*_busy_out=0 and all rs*_tag_out=0.
- Reset asserted mid-operation discards all pending renames immediately; no write is issued in that cycle.
- Lookup-to-output and commit-to-rf_we paths are combinational (0 latency).
- Issue and commit take effect on the table 1 cycle later.
- Flush takes effect at the next edge; busy_count_out reads 0 in the cycle after flush.
- No backpressure: every valid input is consumed in the cycle it is presented.

## Test plan
- Reset, then look up rs1=5, rs2=0 -> both busy=0 and tag=0; busy_count_out=0; rf_we_out=0.
- Issue rd=5 with tag=3. Next cycle look up rs1=5 -> busy=1, tag=3, busy_count_out=1. Commit rd=5, tag=3, data=0xDEADBEEF -> same cycle rs1_busy_out=0, rf_we_out=1, rf_waddr_out=5, rf_wdata_out=0xDEADBEEF. Next cycle busy_count_out=0.
- Issue rd=7 with tag=1, then rd=7 with tag=2. Commit rd=7 with tag=1 -> rf write occurs and rs lookup of x7 stays busy with tag=2. Commit tag=2 -> x7 not busy.
- In the same cycle, issue rd=9 with tag=4 and commit rd=9 with tag=6 (x9 busy with tag 6) -> next cycle x9 busy with tag=4.
- Issue rd=1, 2, 3 on consecutive cycles (count=3). Assert flush_in together with issue rd=4 -> next cycle all four registers not busy and count=0.
- Issue rd=0 and commit rd=0 -> no busy change, rf_we_out=0. Assert rst_in low mid-stream with 3 busy registers -> outputs are zero immediately.

Source files
------------

// File: rtl/reg_status_table.sv
// Register-status table: tracks which architectural registers have an in-flight
// writer (and its ROB tag), sequences the regfile write port from commit, and clears on flush.
module reg_status_table #(
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             issue_valid_in,
  input  logic [4:0]       issue_rd_in,
  input  logic [TAG_W-1:0] issue_tag_in,
  input  logic [4:0]       rs1_addr_in,
  input  logic [4:0]       rs2_addr_in,
  output logic             rs1_busy_out,
  output logic [TAG_W-1:0] rs1_tag_out,
  output logic             rs2_busy_out,
  output logic [TAG_W-1:0] rs2_tag_out,
  input  logic             commit_valid_in,
  input  logic [4:0]       commit_rd_in,
  input  logic [TAG_W-1:0] commit_tag_in,
  input  logic [31:0]      commit_data_in,
  output logic             rf_we_out,
  output logic [4:0]       rf_waddr_out,
  output logic [31:0]      rf_wdata_out,
  output logic [5:0]       busy_count_out
);

  // Handshake: issue and commit are valid-only; each valid input is consumed
  // in the cycle it is presented, there is no ready/backpressure.

  logic [31:0]            busy_q, busy_d;
  logic [31:0][TAG_W-1:0] tag_q, tag_d;
  logic [5:0]             count_q, count_d;

  logic commit_wr;
  logic commit_clr;
  logic issue_set;

  // Entry 0 is held at zero so x0 lookups naturally return not-busy / tag 0.
  function automatic logic [TAG_W:0] lookup(input logic [4:0] a);
    logic hit;
    hit = busy_q[a] & ~(commit_valid_in && (commit_rd_in == a) && (commit_tag_in == tag_q[a]));
    return {hit, (hit ? tag_q[a] : {TAG_W{1'b0}})};
  endfunction

  always_comb begin
    {rs1_busy_out, rs1_tag_out} = lookup(rs1_addr_in);
    {rs2_busy_out, rs2_tag_out} = lookup(rs2_addr_in);
  end

  assign commit_wr  = rst_in & commit_valid_in & (commit_rd_in != 5'd0);
  assign commit_clr = commit_wr & busy_q[commit_rd_in] & (tag_q[commit_rd_in] == commit_tag_in);
  assign issue_set  = issue_valid_in & (issue_rd_in != 5'd0) & ~flush_in;

  assign rf_we_out    = commit_wr;
  assign rf_waddr_out = commit_wr ? commit_rd_in : 5'd0;
  assign rf_wdata_out = commit_wr ? commit_data_in : 32'd0;

  // Issue is applied after commit so a same-cycle rename of the register wins.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_clr) begin
      busy_d[commit_rd_in] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd_in] = 1'b1;
      tag_d[issue_rd_in]  = issue_tag_in;
    end
    if (flush_in) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_comb begin
    count_d = 6'd0;
    for (int i = 1; i < 32; i++) begin
      count_d = count_d + {5'd0, busy_d[i]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q  <= '0;
      tag_q   <= '0;
      count_q <= 6'd0;
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign busy_count_out = count_q;

endmodule
